// File: rtl/ext_bus_ctrl.sv
// External bus controller: fixed-latency chip-selected accesses to NUM_DEV devices
// over a shared tristate data bus, plus a read-only switch register at SW_ADDR.
module ext_bus_ctrl #(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 4,
  parameter int                 NUM_DEV  = 5,
  parameter logic [NUM_DEV-1:0] RD_MASK  = 5'b11011,
  parameter logic [NUM_DEV-1:0] WR_MASK  = 5'b00111,
  parameter int                 SW_ADDR  = 5,
  parameter int                 SW_W     = 8,
  parameter int                 WAIT_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic [DATA_W-1:0]  WriteData,
  input  logic               Read,
  input  logic               Write,
  output logic               Stall,
  output logic [DATA_W-1:0]  DataToCPU,
  output logic               RdValid,
  output logic               ErrAddr,
  inout  wire  [DATA_W-1:0]  DataBus,
  output logic [NUM_DEV-1:0] CS,
  input  logic [SW_W-1:0]    switch
);

  localparam int CNT_W = $clog2(WAIT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  stateT              state, stateNext;
  logic [CNT_W-1:0]   waitCnt;
  logic [ADDR_W-1:0]  addrQ;
  logic [DATA_W-1:0]  wdataQ;
  logic               opWrite;
  logic [NUM_DEV-1:0] devHit;
  logic [NUM_DEV-1:0] opMask;
  logic               swHit;
  logic               legal;
  logic               accept;
  logic               lastAccess;

  always_comb begin
    for (int i = 0; i < NUM_DEV; i++) begin
      devHit[i] = (addrQ == ADDR_W'(i));
    end
  end

  // SW_ADDR lies above the device range, so a switch read never raises a chip select.
  assign opMask     = opWrite ? WR_MASK : RD_MASK;
  assign swHit      = !opWrite && (addrQ == ADDR_W'(SW_ADDR));
  assign legal      = (|(devHit & opMask)) || swHit;
  assign accept     = (state == IDLE) && (Read || Write);
  assign lastAccess = (state == ACCESS) && (waitCnt == '0);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Read || Write) stateNext = ACCESS;
      ACCESS:  if (waitCnt == '0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      DataToCPU <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        waitCnt <= CNT_W'(WAIT_CYC - 1);
      end else if ((state == ACCESS) && (waitCnt != '0)) begin
        waitCnt <= waitCnt - 1'b1;
      end
      if (lastAccess && !opWrite) begin
        if (swHit) begin
          DataToCPU <= DATA_W'(switch);
        end else if (legal) begin
          DataToCPU <= DataBus;
        end else begin
          DataToCPU <= '0;
        end
      end
    end
  end

  // NOTE: request latches carry no reset; they are only observed while the FSM is busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      addrQ   <= Addr;
      wdataQ  <= WriteData;
      opWrite <= Write;
    end
  end

  assign Stall   = (state == ACCESS) || accept;
  assign CS      = (state == ACCESS) ? (devHit & opMask) : '0;
  assign RdValid = (state == DONE) && !opWrite;
  assign ErrAddr = (state == DONE) && !legal;
  assign DataBus = ((state == ACCESS) && opWrite && legal) ? wdataQ : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Self-checking bench for ext_bus_ctrl: directed vector table, reset sequences,
// then randomized traffic against a transaction-timeline reference model.
module tb_ext_bus_ctrl;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_DEV  = 5;
  localparam int SW_ADDR  = 5;
  localparam int SW_W     = 8;
  localparam int WAIT_CYC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic              Read;
  logic              Write;
  logic              Stall;
  logic [DATA_W-1:0] DataToCPU;
  logic              RdValid;
  logic              ErrAddr;
  logic [NUM_DEV-1:0] CS;
  logic [SW_W-1:0]   switch;
  wire  [DATA_W-1:0] DataBus;

  logic              tbDrive;
  logic [DATA_W-1:0] tbBus;
  assign DataBus = tbDrive ? tbBus : {DATA_W{1'bz}};

  int nCompared   = 0;
  int nMismatched = 0;

  bit [NUM_DEV-1:0] rdMask = 5'b11011;
  bit [NUM_DEV-1:0] wrMask = 5'b00111;

  ext_bus_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_DEV(NUM_DEV),
    .RD_MASK(5'b11011), .WR_MASK(5'b00111),
    .SW_ADDR(SW_ADDR), .SW_W(SW_W), .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .WriteData(WriteData),
    .Read(Read), .Write(Write), .Stall(Stall), .DataToCPU(DataToCPU),
    .RdValid(RdValid), .ErrAddr(ErrAddr), .DataBus(DataBus), .CS(CS),
    .switch(switch)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // An undriven bus reads as Z in 4-state simulators and as 0 in 2-state ones.
  function automatic logic busIdle();
    return (DataBus === 16'hzzzz) || (DataBus === 16'h0000);
  endfunction

  function automatic bit isLegal(input int a, input bit wr);
    if (a < NUM_DEV) return wr ? wrMask[a] : rdMask[a];
    return !wr && (a == SW_ADDR);
  endfunction

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    bit                 rd;
    bit                 wr;
    logic [DATA_W-1:0]  wdata;
    logic [SW_W-1:0]    sw;
    logic [DATA_W-1:0]  devVal;
    logic [NUM_DEV-1:0] expCs;
    bit                 devDrives;
    bit                 expBus;
    bit                 expRv;
    bit                 expErr;
    logic [DATA_W-1:0]  expData;
  } vecT;

  vecT vecs[10];

  initial begin
    bit               active;
    int               startCyc;
    int               k;
    logic [ADDR_W-1:0] tA;
    bit               tWr;
    logic [DATA_W-1:0] tWd;
    bit               tLegal;
    logic [DATA_W-1:0] expData;
    logic [DATA_W-1:0] devVal;

    //          addr  rd wr wdata     sw     devVal    cs        drv bus rv err data
    vecs[0] = '{4'd0, 1, 0, 16'h0000, 8'h00, 16'hBEEF, 5'b00001, 1,  0,  1, 0,  16'hBEEF};
    vecs[1] = '{4'd2, 0, 1, 16'h1234, 8'h00, 16'h0000, 5'b00100, 0,  1,  0, 0,  16'hBEEF};
    vecs[2] = '{4'd2, 1, 0, 16'h0000, 8'h00, 16'h0000, 5'b00000, 0,  0,  1, 1,  16'h0000};
    vecs[3] = '{4'd5, 1, 0, 16'h0000, 8'hA5, 16'h0000, 5'b00000, 0,  0,  1, 0,  16'h00A5};
    vecs[4] = '{4'd5, 0, 1, 16'h9999, 8'h00, 16'h0000, 5'b00000, 0,  0,  0, 1,  16'h00A5};
    vecs[5] = '{4'd4, 1, 0, 16'h0000, 8'h00, 16'h5A5A, 5'b10000, 1,  0,  1, 0,  16'h5A5A};
    vecs[6] = '{4'd3, 0, 1, 16'h7777, 8'h00, 16'h0000, 5'b00000, 0,  0,  0, 1,  16'h5A5A};
    vecs[7] = '{4'd9, 1, 0, 16'h0000, 8'h00, 16'h0000, 5'b00000, 0,  0,  1, 1,  16'h0000};
    vecs[8] = '{4'd1, 1, 1, 16'hCAFE, 8'h00, 16'h0000, 5'b00010, 0,  1,  0, 0,  16'h0000};
    vecs[9] = '{4'd1, 1, 0, 16'h0000, 8'h00, 16'h1357, 5'b00010, 1,  0,  1, 0,  16'h1357};

    rst = 1'b1; Read = 1'b0; Write = 1'b0; Addr = '0; WriteData = '0;
    switch = '0; tbDrive = 1'b0; tbBus = '0;
    nextCycle();
    nextCycle();
    @(negedge clk);
    check("reset.stall", Stall, 0);
    check("reset.cs", CS, 0);
    check("reset.rdvalid", RdValid, 0);
    check("reset.err", ErrAddr, 0);
    check("reset.data", DataToCPU, 0);
    check("reset.busz", busIdle(), 1);
    nextCycle();
    rst = 1'b0;

    // Directed table: one access per entry, garbage on the request inputs while busy.
    for (int i = 0; i < 10; i++) begin
      Addr = vecs[i].addr; Read = vecs[i].rd; Write = vecs[i].wr;
      WriteData = vecs[i].wdata; switch = vecs[i].sw; tbDrive = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d.req.stall", i), Stall, 1);
      check($sformatf("v%0d.req.cs", i), CS, 0);
      for (int c = 1; c <= WAIT_CYC; c++) begin
        nextCycle();
        Addr = 4'($urandom); WriteData = 16'($urandom); Read = 1'b1; Write = 1'($urandom);
        tbDrive = vecs[i].devDrives; tbBus = vecs[i].devVal;
        @(negedge clk);
        check($sformatf("v%0d.acc%0d.stall", i, c), Stall, 1);
        check($sformatf("v%0d.acc%0d.cs", i, c), CS, vecs[i].expCs);
        if (vecs[i].expBus) check($sformatf("v%0d.acc%0d.bus", i, c), DataBus, vecs[i].wdata);
        else if (!vecs[i].devDrives) check($sformatf("v%0d.acc%0d.busz", i, c), busIdle(), 1);
      end
      nextCycle();
      Read = 1'b0; Write = 1'b0; tbDrive = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d.done.stall", i), Stall, 0);
      check($sformatf("v%0d.done.cs", i), CS, 0);
      check($sformatf("v%0d.done.rdvalid", i), RdValid, vecs[i].expRv);
      check($sformatf("v%0d.done.err", i), ErrAddr, vecs[i].expErr);
      check($sformatf("v%0d.done.data", i), DataToCPU, vecs[i].expData);
      check($sformatf("v%0d.done.busz", i), busIdle(), 1);
      nextCycle();
      @(negedge clk);
      check($sformatf("v%0d.idle.rdvalid", i), RdValid, 0);
      check($sformatf("v%0d.idle.err", i), ErrAddr, 0);
      check($sformatf("v%0d.idle.data", i), DataToCPU, vecs[i].expData);
      nextCycle();
    end

    // Reset in the middle of a read aborts it and clears DataToCPU.
    Addr = 4'd0; Read = 1'b1;
    @(negedge clk);
    check("abort.req.stall", Stall, 1);
    nextCycle();
    Read = 1'b0; rst = 1'b1; tbDrive = 1'b1; tbBus = 16'h4321;
    @(negedge clk);
    check("abort.acc.cs", CS, 5'b00001);
    nextCycle();
    rst = 1'b0; tbDrive = 1'b0;
    @(negedge clk);
    check("abort.after.cs", CS, 0);
    check("abort.after.stall", Stall, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("abort.c%0d.rdvalid", c), RdValid, 0);
      check($sformatf("abort.c%0d.err", c), ErrAddr, 0);
      check($sformatf("abort.c%0d.data", c), DataToCPU, 0);
      nextCycle();
    end

    // A request held across reset is accepted in the cycle reset drops.
    rst = 1'b1; Read = 1'b1; Addr = 4'd5; switch = 8'h3C;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstreq.first.stall", Stall, 1);
    nextCycle();
    Read = 1'b0;
    @(negedge clk);
    check("rstreq.acc.stall", Stall, 1);
    check("rstreq.acc.cs", CS, 0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    check("rstreq.done.rdvalid", RdValid, 1);
    check("rstreq.done.err", ErrAddr, 0);
    check("rstreq.done.data", DataToCPU, 16'h003C);
    nextCycle();

    // Randomized traffic: model tracks each access by its start cycle and offset.
    active = 1'b0; startCyc = 0; tA = '0; tWr = 1'b0; tWd = '0; tLegal = 1'b0;
    expData = 16'h003C;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit rd, wr, inAccess, inDone, idle;
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 3) == 0);
      Read = rd; Write = wr;
      Addr = 4'($urandom_range(0, 7));
      WriteData = 16'($urandom) | 16'h0001;
      switch = 8'($urandom);
      k = active ? (cyc - startCyc) : 0;
      inAccess = active && (k >= 1) && (k <= WAIT_CYC);
      inDone   = active && (k == WAIT_CYC + 1);
      idle     = !active;
      devVal   = 16'($urandom);
      tbDrive  = inAccess && !tWr && (int'(tA) < NUM_DEV) && tLegal;
      tbBus    = devVal;
      @(negedge clk);
      check("rnd.stall", Stall, inAccess || (idle && (rd || wr)));
      check("rnd.cs", CS, (inAccess && tLegal && (int'(tA) < NUM_DEV)) ? (5'b00001 << tA) : 5'b00000);
      check("rnd.rdvalid", RdValid, inDone && !tWr);
      check("rnd.err", ErrAddr, inDone && !tLegal);
      check("rnd.data", DataToCPU, expData);
      if (inAccess && tWr && tLegal) check("rnd.buswr", DataBus, tWd);
      else if (!tbDrive) check("rnd.busz", busIdle(), 1);
      if (inAccess && (k == WAIT_CYC) && !tWr) begin
        if (int'(tA) == SW_ADDR) expData = 16'(switch);
        else if (tLegal)         expData = devVal;
        else                     expData = 16'h0000;
      end
      if (inDone) active = 1'b0;
      if (idle && (rd || wr)) begin
        active = 1'b1; startCyc = cyc; tA = Addr; tWr = wr; tWd = WriteData;
        tLegal = isLegal(int'(Addr), wr);
      end
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ext_bus_ctrl.md
EXT_BUS_CTRL -- requirements
Module: ext_bus_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 16: data bus / WriteData / DataToCPU width.
- ADDR_W, 4: device-select address width.
- NUM_DEV, 5: number of chip-selected devices; device i is selected by Addr==i.
- RD_MASK, 5'b11011: bit i=1 means device i is readable.
- WR_MASK, 5'b00111: bit i=1 means device i is writable.
- SW_ADDR, 5: address of the internal switch register; must be >= NUM_DEV.
- SW_W, 8: switch input width; must be <= DATA_W.
- WAIT_CYC, 2: bus cycles per access; must be >= 1.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- Addr, input, ADDR_W: device address.
- WriteData, input, DATA_W: CPU write data.
- Read, input, 1: read request.
- Write, input, 1: write request.
- Stall, output, 1: CPU must hold its request and not advance.
- DataToCPU, output, DATA_W: registered read data.
- RdValid, output, 1: one-cycle pulse, read data valid.
- ErrAddr, output, 1: one-cycle pulse, illegal access completed.
- DataBus, inout, DATA_W: shared external data bus.
- CS, output, NUM_DEV: one-hot device chip selects.
- switch, input, SW_W: board switches.
REQ-003 Clocking: one clock domain; reset is synchronous and active-high, ports named clk and rst; all state changes occur on posedge clk.

Function
REQ-004 FSM states: IDLE, ACCESS, DONE.
REQ-005 IDLE, Read|Write=1: latch Addr, WriteData and op; load wait counter with WAIT_CYC-1; next state ACCESS.
- Write has priority when both Read and Write are asserted.
REQ-006 ACCESS: counter decrements each cycle; state moves to DONE in the cycle the counter is 0, so ACCESS lasts exactly WAIT_CYC cycles.
REQ-007 DONE: lasts one cycle, then IDLE. A request present in the following IDLE cycle starts a new access, so back-to-back accesses are spaced WAIT_CYC+2 cycles apart.
REQ-008 Stall = (state==ACCESS) | (state==IDLE & (Read|Write)); Stall=0 in DONE.
REQ-009 Legal access: latched address < NUM_DEV and the op's mask bit is set, or a read of SW_ADDR.
- Any other access is illegal.
- An illegal access still passes through ACCESS for WAIT_CYC cycles.
- It asserts no CS and does not drive DataBus.
- It pulses ErrAddr=1 in DONE.
REQ-010 CS[i]=1 only during ACCESS of a legal access to device i; all CS bits are 0 otherwise, so at most one bit is ever high.
REQ-011 DataBus is driven with the latched WriteData only during ACCESS of a legal write; it is high-Z at all other times.
REQ-012 Read sampling, on the last ACCESS cycle:
- Legal device read: DataBus is registered into DataToCPU.
- SW_ADDR read: zero-extended switch is registered instead.
- Illegal read: DataToCPU is loaded with 0.
REQ-013 RdValid=1 in DONE of every read, legal or illegal; it is 0 for writes.
REQ-014 DataToCPU holds its value until the next read reaches its last ACCESS cycle.
REQ-015 A write to SW_ADDR is illegal and pulses ErrAddr, because the switch register is read-only.
REQ-016 Request inputs are ignored outside IDLE; changes to Addr, WriteData, Read or Write during ACCESS do not affect the access in progress.

Reset
REQ-017 While rst=1 at a clock edge, the next state is:
- FSM state IDLE, counter 0.
- CS=0, RdValid=0, ErrAddr=0, DataToCPU=0.
- DataBus high-Z.
REQ-018 Reset asserted mid-ACCESS aborts the access: no RdValid and no ErrAddr are produced for it, and CS deasserts the cycle after the reset edge.
REQ-019 Stall follows REQ-008 after reset, so the first request in the cycle rst deasserts is accepted.

Verification
REQ-020 Read Addr=0 at cycle 0, bench drives DataBus=16'hBEEF:
- Stall=1 in cycles 0-2, CS[0]=1 in cycles 1-2.
- Cycle 3: Stall=0, RdValid=1, DataToCPU=16'hBEEF.
REQ-021 Write Addr=2, WriteData=16'h1234:
- DataBus=16'h1234 and CS=5'b00100 in cycles 1-2.
- Cycle 3: RdValid=0, ErrAddr=0; bus high-Z from cycle 3.
REQ-022 Read Addr=2 (write-only device): CS=0 throughout; cycle 3 shows ErrAddr=1, RdValid=1, DataToCPU=0.
REQ-023 Read Addr=5, switch=8'hA5: CS=0, DataBus high-Z; cycle 3 shows DataToCPU=16'h00A5, RdValid=1.
REQ-024 Reset mid-read and simultaneous requests:
- Read Addr=0 with rst=1 in cycle 1: cycle 2 shows CS=0, no RdValid afterwards, DataToCPU=0.
- Read=Write=1, Addr=1: a write occurs with CS[1]=1 and DataBus=WriteData.
